// File: rtl/target_locator_pkg.sv
// Shared types and constants for the target locator: coordinate width, FSM states
// and the values the per-frame accumulators return to when a new frame begins.
package target_pkg;

    typedef logic [10:0] coord_t;
    typedef logic [15:0] count_t;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        ACCUM,
        REPORT
    } state_t;

    localparam coord_t ACC_MIN_CLEAR   = 11'd2047;
    localparam coord_t ACC_MAX_CLEAR   = 11'd0;
    localparam count_t ACC_COUNT_CLEAR = 16'd0;
    localparam count_t COUNT_SAT       = 16'hFFFF;

    // Sum is widened by one bit so two maximal coordinates cannot wrap before halving.
    function automatic coord_t midpoint(input coord_t a, input coord_t b);
        logic [11:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return coord_t'(sum >> 1);
    endfunction

endpackage

// File: rtl/target_locator_if.sv
// Pixel stream in, per-frame target report out; the locator sits on the slave side.
interface target_locator_if;
    import target_pkg::*;

    logic   frame_start;
    logic   frame_end;
    logic   pixel_valid;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   pixel_match;

    logic   on_screen;
    coord_t tracked_coordinates_x;
    coord_t tracked_coordinates_y;
    logic   coords_valid;

    modport master (
        output frame_start, frame_end, pixel_valid, pixel_x, pixel_y, pixel_match,
        input  on_screen, tracked_coordinates_x, tracked_coordinates_y, coords_valid
    );

    modport slave (
        input  frame_start, frame_end, pixel_valid, pixel_x, pixel_y, pixel_match,
        output on_screen, tracked_coordinates_x, tracked_coordinates_y, coords_valid
    );

endinterface

// File: rtl/target_locator_axis_extent.sv
// Running min/max of one coordinate axis over a frame, with the midpoint of the extent.
module axis_extent
    import target_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clear_i,
    input  logic   update_i,
    input  coord_t coord_i,
    output coord_t mid_o
);

    coord_t min_q, min_d;
    coord_t max_q, max_d;
    coord_t base_min, base_max;

    // A clear and an update in the same cycle start a fresh extent from this coordinate.
    always_comb begin
        base_min = clear_i ? ACC_MIN_CLEAR : min_q;
        base_max = clear_i ? ACC_MAX_CLEAR : max_q;
        min_d    = base_min;
        max_d    = base_max;
        if (update_i) begin
            if (coord_i < base_min) min_d = coord_i;
            if (coord_i > base_max) max_d = coord_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= ACC_MIN_CLEAR;
            max_q <= ACC_MAX_CLEAR;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign mid_o = midpoint(min_q, max_q);

endmodule

// File: rtl/target_locator.sv
// Frame-based colour target tracker: bounds matched pixels per frame and reports the
// centre of the bounding box, with hysteresis on losing the target.
module target_locator
    import target_pkg::*;
#(
    parameter int MIN_PIXELS    = 16,
    parameter int LOST_FRAMES   = 4,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input logic              clk,
    input logic              rst,
    target_locator_if.slave  loc_if
);

    localparam count_t MIN_COUNT_C  = count_t'(MIN_PIXELS);
    localparam count_t MISS_LIMIT_C = count_t'(LOST_FRAMES);
    localparam coord_t WIDTH_C      = coord_t'(SCREEN_WIDTH);
    localparam coord_t HEIGHT_C     = coord_t'(SCREEN_HEIGHT);

    state_t state_q;
    count_t count_q, count_d, count_base;
    count_t miss_q, miss_inc;
    logic   on_screen_q;
    coord_t coord_x_q, coord_y_q;
    logic   coords_valid_q;

    logic   pixel_ok;
    logic   acc_clear;
    logic   acc_update;
    logic   sighting;
    coord_t mid_x, mid_y;

    assign pixel_ok = loc_if.pixel_valid && loc_if.pixel_match &&
                      (loc_if.pixel_x < WIDTH_C) && (loc_if.pixel_y < HEIGHT_C);

    // frame_start always restarts the accumulators and still takes its own pixel.
    always_comb begin
        acc_clear  = 1'b0;
        acc_update = 1'b0;
        case (state_q)
            WAIT_FRAME: begin
                acc_clear  = loc_if.frame_start;
                acc_update = loc_if.frame_start && pixel_ok;
            end
            ACCUM: begin
                acc_clear  = loc_if.frame_start;
                acc_update = pixel_ok;
            end
            default: begin
                acc_clear  = 1'b0;
                acc_update = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_base = acc_clear ? ACC_COUNT_CLEAR : count_q;
        count_d    = count_base;
        if (acc_update && (count_base != COUNT_SAT)) count_d = count_base + 16'd1;
    end

    assign sighting = (count_q >= MIN_COUNT_C);
    assign miss_inc = (miss_q >= MISS_LIMIT_C) ? MISS_LIMIT_C : miss_q + 16'd1;

    axis_extent u_extent_x (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (acc_clear),
        .update_i (acc_update),
        .coord_i  (loc_if.pixel_x),
        .mid_o    (mid_x)
    );

    axis_extent u_extent_y (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (acc_clear),
        .update_i (acc_update),
        .coord_i  (loc_if.pixel_y),
        .mid_o    (mid_y)
    );

    // Report outputs are only ever loaded on the edge that leaves REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WAIT_FRAME;
            count_q        <= ACC_COUNT_CLEAR;
            miss_q         <= '0;
            on_screen_q    <= 1'b0;
            coord_x_q      <= '0;
            coord_y_q      <= '0;
            coords_valid_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            coords_valid_q <= 1'b0;
            case (state_q)
                WAIT_FRAME: begin
                    if (loc_if.frame_start) state_q <= ACCUM;
                end
                ACCUM: begin
                    if (loc_if.frame_start)    state_q <= ACCUM;
                    else if (loc_if.frame_end) state_q <= REPORT;
                end
                REPORT: begin
                    state_q        <= WAIT_FRAME;
                    coords_valid_q <= 1'b1;
                    if (sighting) begin
                        coord_x_q   <= mid_x;
                        coord_y_q   <= mid_y;
                        miss_q      <= '0;
                        on_screen_q <= 1'b1;
                    end else begin
                        miss_q <= miss_inc;
                        if (miss_inc >= MISS_LIMIT_C) on_screen_q <= 1'b0;
                    end
                end
                default: state_q <= WAIT_FRAME;
            endcase
        end
    end

    assign loc_if.on_screen             = on_screen_q;
    assign loc_if.tracked_coordinates_x = coord_x_q;
    assign loc_if.tracked_coordinates_y = coord_y_q;
    assign loc_if.coords_valid          = coords_valid_q;

endmodule

// File: tb/tb_target_locator.sv
// Directed bench for target_locator: stimulus pushes expected reports into a queue and an
// independent negedge monitor pops and compares them whenever coords_valid pulses.
module tb_target_locator;

    typedef struct {
        logic        onScreen;
        logic [31:0] x;
        logic [31:0] y;
        int          cycle;
    } exp_t;

    logic clk;
    logic rst;
    int   testsRun;
    int   failures;
    int   negCount;
    exp_t expQ[$];
    exp_t monE;

    target_locator_if bus ();

    target_locator #(
        .MIN_PIXELS    (4),
        .LOST_FRAMES   (2),
        .SCREEN_WIDTH  (640),
        .SCREEN_HEIGHT (480)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .loc_if (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected reports left %0d", expQ.size());
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every coords_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        negCount++;
        if (bus.coords_valid !== 1'b0) begin
            if (expQ.size() == 0) begin
                testsRun++;
                failures++;
                $display("[TB] FAIL unexpected_report: coords_valid=%b expected 0 at cycle %0d",
                         bus.coords_valid, negCount);
            end else begin
                monE = expQ.pop_front();
                checkOutput("report_cycle", negCount, monE.cycle);
                checkOutput("report_on_screen", {31'd0, bus.on_screen}, {31'd0, monE.onScreen});
                checkOutput("report_x", {21'd0, bus.tracked_coordinates_x}, monE.x);
                checkOutput("report_y", {21'd0, bus.tracked_coordinates_y}, monE.y);
            end
        end
    end

    task automatic applyStimulus(input logic fs, input logic fe, input logic pv, input logic pm,
                                 input int x, input int y);
        bus.frame_start = fs;
        bus.frame_end   = fe;
        bus.pixel_valid = pv;
        bus.pixel_match = pm;
        bus.pixel_x     = 11'(x);
        bus.pixel_y     = 11'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int x, input int y);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, x, y);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Called right after the frame_end cycle; the report is due two negedges later.
    task automatic expectReport(input logic onScreen, input int x, input int y);
        exp_t e;
        e.onScreen = onScreen;
        e.x        = 32'(x);
        e.y        = 32'(y);
        e.cycle    = negCount + 2;
        expQ.push_back(e);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_on_screen"}, {31'd0, bus.on_screen}, 32'd0);
        checkOutput({tag, "_x"}, {21'd0, bus.tracked_coordinates_x}, 32'd0);
        checkOutput({tag, "_y"}, {21'd0, bus.tracked_coordinates_y}, 32'd0);
        checkOutput({tag, "_coords_valid"}, {31'd0, bus.coords_valid}, 32'd0);
    endtask

    task automatic smallFrame(input int nMatches);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < nMatches; i++) px(300 + 10 * i, 300 + 10 * i);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        testsRun = 0;
        failures = 0;
        negCount = 0;
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.pixel_match = 1'b0;
        bus.pixel_x     = '0;
        bus.pixel_y     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;

        // Matched pixels while waiting for a frame must be ignored.
        px(0, 0);
        px(5, 5);

        // Basic sighting with ignored non-matching and non-valid pixels.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        px(100, 50);
        px(120, 60);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5, 5);
        px(110, 55);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 900, 900);
        px(105, 52);
        px(101, 58);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        expectReport(1'b1, 110, 55);
        idle(3);

        // Misses: first keeps on_screen, second drops it, third saturates.
        smallFrame(3);
        expectReport(1'b1, 110, 55);
        idle(2);
        smallFrame(3);
        expectReport(1'b0, 110, 55);
        idle(2);
        smallFrame(0);
        expectReport(1'b0, 110, 55);
        idle(2);

        // Screen-edge pixels: only those strictly inside the active area count.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        px(639, 479);
        px(640, 100);
        px(100, 480);
        px(639, 479);
        px(639, 479);
        px(639, 479);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        expectReport(1'b1, 639, 479);
        idle(2);

        // Restart mid-frame; frame_start beats a simultaneous frame_end and keeps its pixel.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) px(0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 200, 300);
        px(200, 300);
        px(200, 300);
        px(200, 300);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        expectReport(1'b1, 200, 300);
        idle(2);

        // Reset in the middle of accumulation, then a stray frame_end and pixels.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        px(50, 50);
        px(50, 50);
        rst = 1'b1;
        px(60, 60);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        px(70, 70);
        px(80, 80);
        idle(3);
        checkResetState("rst_accum");

        // Reset landing on the report cycle suppresses the report.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) px(400, 400);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);
        checkResetState("rst_report");

        // Pixels in both the frame_start and frame_end cycles are counted.
        px(600, 400);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 10, 20);
        px(30, 40);
        px(20, 30);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 50, 60);
        expectReport(1'b1, 30, 40);
        idle(2);

        // Single miss after a fresh sighting keeps the target on screen.
        smallFrame(2);
        expectReport(1'b1, 30, 40);
        idle(5);

        checkOutput("pending_reports", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
